// File: rtl/seg7_scan_driver.sv
// Multiplexed hex-to-7-segment scan driver; optional leading-zero blanking via SEG7_LZB_EN.
// Latency: registered outputs, one cycle behind idx/display; loads show at next frame wrap.
// Backpressure: none; loads are always accepted, and the last load before a wrap is displayed.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  wrap;
    logic [4*DIGITS-1:0]   shadow_val;
    logic [DIGITS-1:0]     shadow_dp;
    logic [4*DIGITS-1:0]   disp_val;
    logic [DIGITS-1:0]     disp_dp;
    logic                  pending;
    logic [3:0]            nib;
    logic                  nib_dp;
    logic                  blank;
    logic [DIGITS-1:0]     onehot;
    logic [6:0]            glyph;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // The wrap copies the shadow as it stood before this edge; a load on the
    // same edge stays pending for the following wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else begin
            if (wrap && pending) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end else if (wrap) begin
                pending    <= 1'b0;
            end
        end
    end

    always_comb begin
        nib    = 4'h0;
        nib_dp = 1'b0;
        blank  = 1'b0;
        onehot = '0;
`ifdef SEG7_LZB_EN
        begin : lzb
            logic zero_above;
            logic zero_here;
            zero_above = 1'b1;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                zero_here = zero_above && (disp_val[4*i +: 4] == 4'h0);
                if (idx == IW'(i))
                    blank = (i > 0) && zero_here && !disp_dp[i];
                zero_above = zero_here;
            end
        end
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = disp_val[4*i +: 4];
                nib_dp    = disp_dp[i];
                onehot[i] = 1'b1;
            end
        end
    end

    // Stored as {g,f,e,d,c,b,a} so bit 0 lands on segment a.
    always_comb begin
        case (nib)
            4'h0:    glyph = 7'b0111111;
            4'h1:    glyph = 7'b0000110;
            4'h2:    glyph = 7'b1011011;
            4'h3:    glyph = 7'b1001111;
            4'h4:    glyph = 7'b1100110;
            4'h5:    glyph = 7'b1101101;
            4'h6:    glyph = 7'b1111101;
            4'h7:    glyph = 7'b0000111;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1101111;
            4'hA:    glyph = 7'b1110111;
            4'hB:    glyph = 7'b1111100;
            4'hC:    glyph = 7'b0111001;
            4'hD:    glyph = 7'b1011110;
            4'hE:    glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= {7{ACTIVE_LOW}};
            dp         <= ACTIVE_LOW;
            an         <= {DIGITS{ACTIVE_LOW}};
            frame_done <= 1'b0;
        end else begin
            seg        <= (blank ? 7'b0000000 : glyph) ^ {7{ACTIVE_LOW}};
            dp         <= nib_dp ^ ACTIVE_LOW;
            an         <= onehot ^ {DIGITS{ACTIVE_LOW}};
            frame_done <= wrap;
        end
    end

endmodule
